// File: rtl/divider_unsigned_seq.sv
// rtl/divider_unsigned_seq.sv - iterative restoring unsigned divider, one quotient bit per clock
// Quotient bits shift into the dividend register as dividend bits shift out into the partial remainder.
module divider_unsigned_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // The remainder stays below the divisor, so the borrow bit of the
   // trial subtraction alone decides whether the divisor fits.
   assign rem_sh = {rem, q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (i_valid) state_nxt = S_RUN;
         S_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_DONE;
         S_DONE: if (i_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready     = (state == S_IDLE);
      o_busy      = (state == S_RUN);
      o_valid     = (state == S_DONE);
      o_quotient  = '0;
      o_remainder = '0;
      if (state == S_DONE) begin
         o_quotient  = q;
         o_remainder = rem;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         rem <= '0;
         dvs <= '0;
         cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  q   <= i_dividend;
                  dvs <= i_divisor;
                  rem <= '0;
                  cnt <= '0;
               end
            end
            S_RUN: begin
               q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
               rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
               cnt <= cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_unsigned_seq.sv
// tb/tb_divider_unsigned_seq.sv - self-checking bench for divider_unsigned_seq
// Directed vector table, reset-mid-operation sequence, and randomized ops against a plain-arithmetic model.
module tb_divider_unsigned_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_dividend;
   logic [W-1:0] i_divisor;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_quotient;
   logic [W-1:0] o_remainder;
   logic         o_busy;

   int n_checks = 0;
   int n_pass   = 0;

   divider_unsigned_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_dividend  (i_dividend),
      .i_divisor   (i_divisor),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_quotient  (o_quotient),
      .o_remainder (o_remainder),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           hold;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Unsigned division as DIVU/REMU define it, including divide by zero.
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return {{W{1'b1}}, a};
      return {a / b, a % b};
   endfunction

   // Presents one operand pair, measures latency and busy time, applies
   // hold cycles of backpressure, then retires the result.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int busy_cnt);
      int t;
      q = '0; r = '0; lat = 0; busy_cnt = 0;
      t = 0;
      while (!o_ready && t < 50) begin tick(); t++; end
      if (!o_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      i_valid    = 1'b1;
      i_dividend = a;
      i_divisor  = b;
      tick();
      i_dividend = $urandom;
      i_divisor  = $urandom;
      if (o_busy) busy_cnt++;
      while (!o_valid && lat < 100) begin
         tick();
         lat++;
         if (o_busy) busy_cnt++;
         i_dividend = $urandom;
         i_divisor  = $urandom;
      end
      i_valid = 1'b0;
      if (!o_valid) begin
         check("valid_timeout", 0, 1);
         return;
      end
      q = o_quotient;
      r = o_remainder;
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", o_valid, 1);
         check("hold_ready", o_ready, 0);
         check("hold_q", o_quotient, q);
         check("hold_r", o_remainder, r);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("retire_valid", o_valid, 0);
      check("retire_ready", o_ready, 1);
   endtask

   initial begin
      vec_t         vecs[8];
      logic [W-1:0] q, r, a, b;
      logic [2*W-1:0] m;
      int           lat, busy_cnt, t;

      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,        5};
      vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,        0};
      vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,        1};
      vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,        0};
      vecs[4] = '{32'd0,          32'd3,          32'd0,          32'd0,        0};
      vecs[5] = '{32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h1234,     2};
      vecs[6] = '{32'd1000,       32'd3,          32'd333,        32'd1,        0};
      vecs[7] = '{32'h8000_0000,  32'h0000_0003,  32'h2AAA_AAAA,  32'd2,        0};

      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_dividend = '0; i_divisor = '0;
      tick(); tick();
      check("rst_valid", o_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_q", o_quotient, 0);
      check("rst_r", o_remainder, 0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", o_ready, 1);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].hold, q, r, lat, busy_cnt);
         check($sformatf("vec%0d_q", i), q, vecs[i].q);
         check($sformatf("vec%0d_r", i), r, vecs[i].r);
         check($sformatf("vec%0d_lat", i), lat, W);
         check($sformatf("vec%0d_busy", i), busy_cnt, W);
      end

      // Reset in the middle of an operation discards it.
      i_valid = 1'b1; i_dividend = 32'd1000; i_divisor = 32'd3;
      tick();
      i_valid = 1'b0;
      for (int s = 0; s < 10; s++) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_valid", o_valid, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_q", o_quotient, 0);
      check("midrst_r", o_remainder, 0);
      #2;
      rst_n = 1'b1;
      #1;
      check("midrst_ready", o_ready, 1);
      t = 0;
      for (int s = 0; s < 40; s++) begin
         tick();
         if (o_valid || o_busy) t++;
      end
      check("midrst_no_result", t, 0);
      run_op(32'd81, 32'd9, 0, q, r, lat, busy_cnt);
      check("post_rst_q", q, 9);
      check("post_rst_r", r, 0);

      for (int n = 0; n < 1200; n++) begin
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = '0; end
            1: begin a = $urandom; b = $urandom_range(1, 255); end
            2: begin a = $urandom >> 8; b = $urandom | 32'h0100_0000; end
            default: begin a = $urandom; b = $urandom; end
         endcase
         run_op(a, b, $urandom_range(0, 2), q, r, lat, busy_cnt);
         m = ref_div(a, b);
         check("rand_q", q, m[2*W-1:W]);
         check("rand_r", r, m[W-1:0]);
         check("rand_lat", lat, W);
         if (b != 0) begin
            check("rand_inv_sum", 64'(q) * 64'(b) + 64'(r), 64'(a));
            check("rand_inv_lt", r < b, 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
